// File: rtl/dm_responder_if.sv
`default_nettype none
// =====================================================================
// Module  : dm_responder_if
// Brief   : MEM-stage data-memory request/response bundle.
// Rev     : 1.0
// =====================================================================
interface dm_responder_if;
   logic [15:0] dm_addr;
   logic        dm_re;
   logic        dm_we;
   logic [15:0] dm_in;
   logic [15:0] dm_out;
   logic        rdy;
   logic        stall;

   modport master (
      output dm_addr, dm_re, dm_we, dm_in,
      input  dm_out, rdy, stall
   );

   modport slave (
      input  dm_addr, dm_re, dm_we, dm_in,
      output dm_out, rdy, stall
   );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// =====================================================================
// Module  : dm_responder
// Brief   : Latency-accurate handshaked data memory; optional posted-write
//           buffer enabled with `define DM_WRITE_BUFFER_EN.
// Rev     : 1.0
// =====================================================================
module dm_responder #(
   parameter int ADDR_BITS = 12,
   parameter int LATENCY   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   dm_responder_if.slave bus
);
   localparam int         C_DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [15:0]          data_q, data_d;
   logic                 wr_q, wr_d;
   logic [15:0]          dm_out_q;
   logic [15:0]          mem [C_DEPTH];

   logic                 w_req;
   logic                 w_start;
   logic                 w_fire;
   logic                 w_op_wr;
   logic [ADDR_BITS-1:0] w_op_addr;
   logic [15:0]          w_op_data;
   logic [15:0]          w_rd_data;
   logic                 w_mem_we;
   logic [ADDR_BITS-1:0] w_mem_waddr;
   logic [15:0]          w_mem_wdata;

`ifdef DM_WRITE_BUFFER_EN
   localparam logic [3:0] C_LAT = 4'(LATENCY);

   logic                 buf_valid_q;
   logic [ADDR_BITS-1:0] buf_addr_q;
   logic [15:0]          buf_data_q;
   logic [3:0]           drain_cnt_q;
   logic                 w_buf_cap;
`endif

   assign w_req     = bus.dm_re | bus.dm_we;
   // In IDLE the operation is taken straight from the bus so LATENCY==1 needs no extra cycle.
   assign w_op_addr = (state_q == S_IDLE) ? bus.dm_addr[ADDR_BITS-1:0] : addr_q;
   assign w_op_data = (state_q == S_IDLE) ? bus.dm_in : data_q;
   assign w_op_wr   = (state_q == S_IDLE) ? bus.dm_we : wr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = wr_q;
      w_start = 1'b0;
      w_fire  = 1'b0;
`ifdef DM_WRITE_BUFFER_EN
      w_buf_cap = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
`ifdef DM_WRITE_BUFFER_EN
               if (bus.dm_we) begin
                  if (!buf_valid_q) begin
                     w_buf_cap = 1'b1;
                     state_d   = S_RESP;
                  end
               end else begin
                  w_start = 1'b1;
               end
`else
               w_start = 1'b1;
`endif
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               w_fire  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (w_start) begin
         addr_d = bus.dm_addr[ADDR_BITS-1:0];
         data_d = bus.dm_in;
         wr_d   = bus.dm_we;
         if (LATENCY == 1) begin
            state_d = S_RESP;
            w_fire  = 1'b1;
         end else begin
            state_d = S_BUSY;
            cnt_d   = C_CNT_INIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         data_q   <= 16'h0000;
         wr_q     <= 1'b0;
         dm_out_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         if (w_fire && !w_op_wr) begin
            dm_out_q <= w_rd_data;
         end
      end
   end

`ifdef DM_WRITE_BUFFER_EN
   // The buffer always holds the newest store, so a matching read must see it over the array.
   assign w_rd_data   = (buf_valid_q && (buf_addr_q == w_op_addr)) ? buf_data_q : mem[w_op_addr];
   assign w_mem_we    = buf_valid_q && (drain_cnt_q == 4'd1);
   assign w_mem_waddr = buf_addr_q;
   assign w_mem_wdata = buf_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= 16'h0000;
         drain_cnt_q <= 4'd0;
      end else if (w_buf_cap) begin
         buf_valid_q <= 1'b1;
         buf_addr_q  <= w_op_addr;
         buf_data_q  <= w_op_data;
         drain_cnt_q <= C_LAT;
      end else if (buf_valid_q) begin
         drain_cnt_q <= drain_cnt_q - 4'd1;
         if (drain_cnt_q == 4'd1) begin
            buf_valid_q <= 1'b0;
         end
      end
   end
`else
   assign w_rd_data   = mem[w_op_addr];
   assign w_mem_we    = w_fire && w_op_wr;
   assign w_mem_waddr = w_op_addr;
   assign w_mem_wdata = w_op_data;
`endif

   // Gating with rst_n keeps a reset coinciding with the commit edge from landing the write.
   always_ff @(posedge clk) begin
      if (rst_n && w_mem_we) begin
         mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   generate
      if (ADDR_BITS < 16) begin : g_addr_alias
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^bus.dm_addr[15:ADDR_BITS];
      end
   endgenerate

   assign bus.rdy    = (state_q == S_RESP);
   assign bus.stall  = w_req & ~bus.rdy;
   assign bus.dm_out = dm_out_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// =====================================================================
// Module  : tb_dm_responder
// Brief   : Randomised self-checking bench; instance 0 LATENCY=3, instance 1 LATENCY=1.
// Rev     : 1.0
// =====================================================================
module tb_dm_responder;
   localparam int ABITS = 12;
   localparam int DEPTH = 1 << ABITS;
   localparam int LAT0  = 3;
   localparam int LAT1  = 1;
`ifdef DM_WRITE_BUFFER_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_nv  [2];
   logic [15:0] d_addr  [2];
   logic        d_re    [2];
   logic        d_we    [2];
   logic [15:0] d_in    [2];
   logic [15:0] q_out   [2];
   logic        q_rdy   [2];
   logic        q_stall [2];

   dm_responder_if if0 ();
   dm_responder_if if1 ();

   assign if0.dm_addr = d_addr[0];
   assign if0.dm_re   = d_re[0];
   assign if0.dm_we   = d_we[0];
   assign if0.dm_in   = d_in[0];
   assign if1.dm_addr = d_addr[1];
   assign if1.dm_re   = d_re[1];
   assign if1.dm_we   = d_we[1];
   assign if1.dm_in   = d_in[1];
   assign q_out[0]    = if0.dm_out;
   assign q_rdy[0]    = if0.rdy;
   assign q_stall[0]  = if0.stall;
   assign q_out[1]    = if1.dm_out;
   assign q_rdy[1]    = if1.rdy;
   assign q_stall[1]  = if1.stall;

   dm_responder #(.ADDR_BITS(ABITS), .LATENCY(LAT0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_nv[0]),
      .bus   (if0.slave)
   );

   dm_responder #(.ADDR_BITS(ABITS), .LATENCY(LAT1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_nv[1]),
      .bus   (if1.slave)
   );

   // Reference model: last value written per word, current read-data register, buffer drain edge.
   logic [15:0] ref_mem [2][DEPTH];
   bit          ref_ok  [2][DEPTH];
   logic [15:0] cur_out [2];
   int          drain_edge [2];

   logic        exp_rdy   [2];
   logic        exp_stall [2];
   logic [15:0] exp_out   [2];
   bit          chk_en    [2];

   int cyc     = 0;
   int n_pass  = 0;
   int n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   task automatic check(string name, int k, logic [15:0] act, logic [15:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, k, cyc, act, expv);
   endtask

   task automatic set_exp(int k, logic r, logic s, logic [15:0] o);
      exp_rdy[k]   = r;
      exp_stall[k] = s;
      exp_out[k]   = o;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (chk_en[k]) begin
            check("rdy",    k, 16'(q_rdy[k]),   16'(exp_rdy[k]));
            check("stall",  k, 16'(q_stall[k]), 16'(exp_stall[k]));
            check("dm_out", k, q_out[k],        exp_out[k]);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int k, int n);
      d_re[k] = 1'b0;
      d_we[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         set_exp(k, 1'b0, 1'b0, cur_out[k]);
         next_cycle();
      end
      set_exp(k, 1'b0, 1'b0, cur_out[k]);
   endtask

   // Edge at which the request is accepted and the cycle in which rdy must be seen.
   task automatic schedule(int k, bit we, output int acc, output int rc);
      int r;
      r = cyc + 1;
      if (POSTED && we) begin
         acc = (drain_edge[k] + 1 > r) ? drain_edge[k] + 1 : r;
         rc  = acc;
         drain_edge[k] = acc + lat_of(k);
      end else begin
         acc = r;
         rc  = acc + lat_of(k) - 1;
      end
   endtask

   task automatic access(int k, bit re, bit we, logic [15:0] addr, logic [15:0] data);
      int acc, rc, idx;
      idx = int'(addr) % DEPTH;
      schedule(k, we, acc, rc);
      d_addr[k] = addr;
      d_in[k]   = data;
      d_re[k]   = re;
      d_we[k]   = we;
      if (we) begin
         ref_mem[k][idx] = data;
         ref_ok[k][idx]  = 1'b1;
      end
      while (cyc <= rc) begin
         if (cyc == rc) begin
            if (re && !we) cur_out[k] = ref_mem[k][idx];
            set_exp(k, 1'b1, 1'b0, cur_out[k]);
         end else begin
            set_exp(k, 1'b0, 1'b1, cur_out[k]);
         end
         next_cycle();
      end
      d_re[k] = 1'b0;
      d_we[k] = 1'b0;
      set_exp(k, 1'b0, 1'b0, cur_out[k]);
   endtask

   // Write that is hit by reset in the cycle right after it is accepted.
   task automatic abort_write(int k, logic [15:0] addr, logic [15:0] data);
      int acc, rc, effect, idx;
      idx = int'(addr) % DEPTH;
      schedule(k, 1'b1, acc, rc);
      effect = POSTED ? acc + lat_of(k) : acc + lat_of(k) - 1;
      d_addr[k] = addr;
      d_in[k]   = data;
      d_re[k]   = 1'b0;
      d_we[k]   = 1'b1;
      while (cyc < acc) begin
         set_exp(k, 1'b0, 1'b1, cur_out[k]);
         next_cycle();
      end
      rst_nv[k] = 1'b0;
      d_we[k]   = 1'b0;
      if (effect <= acc) begin
         ref_mem[k][idx] = data;
         ref_ok[k][idx]  = 1'b1;
      end
      cur_out[k]    = 16'h0000;
      drain_edge[k] = -100;
      set_exp(k, 1'b0, 1'b0, 16'h0000);
      next_cycle();
      rst_nv[k] = 1'b1;
      set_exp(k, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic seq(int k);
      int          op, gap, idx;
      logic [15:0] a16, dat;
      rst_nv[k]     = 1'b0;
      d_addr[k]     = 16'h0000;
      d_in[k]       = 16'h0000;
      d_re[k]       = 1'b0;
      d_we[k]       = 1'b0;
      cur_out[k]    = 16'h0000;
      drain_edge[k] = -100;
      set_exp(k, 1'b0, 1'b0, 16'h0000);
      chk_en[k]     = 1'b1;
      next_cycle();
      next_cycle();
      rst_nv[k] = 1'b1;
      check("reset_out", k, q_out[k], 16'h0000);
      check("reset_rdy", k, 16'(q_rdy[k]), 16'h0000);

      access(k, 1'b0, 1'b1, 16'h0005, 16'hA0A0);
      idle(k, lat_of(k) + 1);
      access(k, 1'b1, 1'b0, 16'h0005, 16'h0000);
      check("rd_A0A0", k, q_out[k], 16'hA0A0);
      idle(k, 2);
      check("hold_A0A0", k, q_out[k], 16'hA0A0);

      access(k, 1'b0, 1'b1, 16'h0002, 16'hBABA);
      access(k, 1'b1, 1'b0, 16'h0002, 16'h0000);
      check("rd_BABA", k, q_out[k], 16'hBABA);

      access(k, 1'b1, 1'b1, 16'h1002, 16'h1234);
      check("both_keep", k, q_out[k], 16'hBABA);
      access(k, 1'b1, 1'b0, 16'h0002, 16'h0000);
      check("alias_1234", k, q_out[k], 16'h1234);

      access(k, 1'b0, 1'b1, 16'h0006, 16'hABCD);
      access(k, 1'b1, 1'b0, 16'h0006, 16'h0000);
      check("rd_ABCD", k, q_out[k], 16'hABCD);
      access(k, 1'b0, 1'b1, 16'h0006, 16'h5555);
      access(k, 1'b0, 1'b1, 16'h0009, 16'h9999);
      access(k, 1'b1, 1'b0, 16'h0009, 16'h0000);
      check("rd_9999", k, q_out[k], 16'h9999);

      access(k, 1'b0, 1'b1, 16'h0000, 16'h0F0F);
      access(k, 1'b0, 1'b1, 16'h0001, 16'hF0F0);
      idle(k, lat_of(k) + 2);
      access(k, 1'b1, 1'b0, 16'h0000, 16'h0000);
      check("b2b_rd0", k, q_out[k], 16'h0F0F);
      access(k, 1'b1, 1'b0, 16'h0001, 16'h0000);
      check("b2b_rd1", k, q_out[k], 16'hF0F0);

      access(k, 1'b0, 1'b1, 16'h0007, 16'h7777);
      idle(k, lat_of(k) + 3);
      abort_write(k, 16'h0007, 16'hFFFF);
      check("abort_out", k, q_out[k], 16'h0000);
      access(k, 1'b1, 1'b0, 16'h0007, 16'h0000);

      for (int t = 0; t < 80; t++) begin
         op  = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, 11));
         a16 = {4'($urandom_range(0, 15)), 12'(idx)};
         dat = 16'($urandom);
         if (op <= 4 && ref_ok[k][idx]) access(k, 1'b1, 1'b0, a16, dat);
         else if (op <= 7)              access(k, 1'b0, 1'b1, a16, dat);
         else                           access(k, 1'b1, 1'b1, a16, dat);
         gap = int'($urandom_range(0, 2));
         idle(k, gap);
      end
      idle(k, 2);
   endtask

   initial begin
      chk_en[0] = 1'b0;
      chk_en[1] = 1'b0;
      fork
         seq(0);
         seq(1);
      join
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
